// File: rtl/logic_axi4_lite_register_bank_pkg.sv
// rtl/logic_axi4_lite_register_bank_pkg.sv - shared types and index helpers for the AXI4-Lite register bank
// Contents: response_t (bresp/rresp encoding), read_state_t (read channel FSM states),
//           default geometry, and constant functions that derive the register index
//           field from the address width and beat size.
package logic_axi4_lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } response_t;

    typedef enum logic {
        READ_IDLE,
        READ_RESP
    } read_state_t;

    localparam int DEFAULT_DATA_BYTES    = 4;
    localparam int DEFAULT_ADDRESS_WIDTH = 8;
    localparam int DEFAULT_REGISTERS     = 4;

    // Lowest address bit that belongs to the register index; bits below select a byte.
    function automatic int index_lsb(input int data_bytes);
        return $clog2(data_bytes);
    endfunction

    // Width of the register index field carved out of the byte address.
    function automatic int index_width(input int address_width, input int data_bytes);
        return address_width - $clog2(data_bytes);
    endfunction

endpackage

// File: rtl/logic_axi4_lite_register_bank_if.sv
// rtl/logic_axi4_lite_register_bank_if.sv - AXI4-Lite bus bundle with master/slave views
// Signals: AW (awvalid/awready/awaddr), W (wvalid/wready/wdata/wstrb),
//          B (bvalid/bready/bresp), AR (arvalid/arready/araddr),
//          R (rvalid/rready/rdata/rresp). The master modport drives valids and
//          bready/rready; the slave modport drives readies and responses.
interface logic_axi4_lite_register_bank_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_BYTES    = 4
);
    logic                       awvalid;
    logic                       awready;
    logic [ADDRESS_WIDTH-1:0]   awaddr;
    logic                       wvalid;
    logic                       wready;
    logic [8*DATA_BYTES-1:0]    wdata;
    logic [DATA_BYTES-1:0]      wstrb;
    logic                       bvalid;
    logic                       bready;
    logic [1:0]                 bresp;
    logic                       arvalid;
    logic                       arready;
    logic [ADDRESS_WIDTH-1:0]   araddr;
    logic                       rvalid;
    logic                       rready;
    logic [8*DATA_BYTES-1:0]    rdata;
    logic [1:0]                 rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/logic_axi4_lite_register_bank_write.sv
// rtl/logic_axi4_lite_register_bank_write.sv - write channel: AW/W capture, commit strobe, B response
// Ports: aclk, areset_n (async, active-low); AW, W and B channel signals;
//        commit (one-cycle, the edge that completes the later of AW/W),
//        index/strobe/data (the write to apply at commit), in_range (index valid).
module logic_axi4_lite_register_bank_write
    import logic_axi4_lite_pkg::*;
#(
    parameter int DATA_BYTES    = DEFAULT_DATA_BYTES,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int REGISTERS     = DEFAULT_REGISTERS,
    localparam int LSB          = index_lsb(DATA_BYTES),
    localparam int IDX_W        = index_width(ADDRESS_WIDTH, DATA_BYTES)
) (
    input  logic                       aclk,
    input  logic                       areset_n,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [ADDRESS_WIDTH-1:0]   awaddr,
    input  logic                       wvalid,
    output logic                       wready,
    input  logic [8*DATA_BYTES-1:0]    wdata,
    input  logic [DATA_BYTES-1:0]      wstrb,
    output logic                       bvalid,
    input  logic                       bready,
    output logic [1:0]                 bresp,
    output logic                       commit,
    output logic [IDX_W-1:0]           index,
    output logic [DATA_BYTES-1:0]      strobe,
    output logic [8*DATA_BYTES-1:0]    data,
    output logic                       in_range
);
    logic                    aw_captured;
    logic                    w_captured;
    logic [IDX_W-1:0]        aw_index_q;
    logic [8*DATA_BYTES-1:0] w_data_q;
    logic [DATA_BYTES-1:0]   w_strb_q;
    logic                    bvalid_q;
    response_t               bresp_q;
    logic                    aw_hs;
    logic                    w_hs;
    logic                    unused_awaddr_bits;

    // Byte-select bits of the address are deliberately ignored.
    assign unused_awaddr_bits = ^awaddr;

    assign awready = !aw_captured && !bvalid_q;
    assign wready  = !w_captured && !bvalid_q;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    // A beat handshaking this cycle is used directly so commit needs no extra cycle.
    assign index  = aw_hs ? awaddr[ADDRESS_WIDTH-1:LSB] : aw_index_q;
    assign data   = w_hs ? wdata : w_data_q;
    assign strobe = w_hs ? wstrb : w_strb_q;

    assign in_range = ({1'b0, index} < (IDX_W+1)'(REGISTERS));
    assign commit   = (aw_captured || aw_hs) && (w_captured || w_hs) && !bvalid_q;

    assign bvalid = bvalid_q;
    assign bresp  = bresp_q;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            aw_captured <= 1'b0;
            w_captured  <= 1'b0;
            aw_index_q  <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
        end else if (bvalid_q) begin
            // Captured flags stay set while the response waits so no new beat is taken.
            if (bready) begin
                bvalid_q    <= 1'b0;
                aw_captured <= 1'b0;
                w_captured  <= 1'b0;
            end
        end else begin
            if (aw_hs) begin
                aw_captured <= 1'b1;
                aw_index_q  <= awaddr[ADDRESS_WIDTH-1:LSB];
            end
            if (w_hs) begin
                w_captured <= 1'b1;
                w_data_q   <= wdata;
                w_strb_q   <= wstrb;
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

endmodule

// File: rtl/logic_axi4_lite_register_bank.sv
// rtl/logic_axi4_lite_register_bank.sv - AXI4-Lite slave holding a bank of byte-writable registers
// Ports: aclk, areset_n (async, active-low); bus (AXI4-Lite slave view);
//        registers (flattened contents, register i at slice i);
//        written (one-cycle pulse per register after a byte update).
module logic_axi4_lite_register_bank
    import logic_axi4_lite_pkg::*;
#(
    parameter int DATA_BYTES    = DEFAULT_DATA_BYTES,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int REGISTERS     = DEFAULT_REGISTERS
) (
    input  logic                               aclk,
    input  logic                               areset_n,
    logic_axi4_lite_register_bank_if.slave     bus,
    output logic [REGISTERS*8*DATA_BYTES-1:0]  registers,
    output logic [REGISTERS-1:0]               written
);
    localparam int DW    = 8 * DATA_BYTES;
    localparam int LSB   = index_lsb(DATA_BYTES);
    localparam int IDX_W = index_width(ADDRESS_WIDTH, DATA_BYTES);

    logic                  commit;
    logic [IDX_W-1:0]      wr_index;
    logic [DATA_BYTES-1:0] wr_strobe;
    logic [DW-1:0]         wr_data;
    logic                  wr_in_range;

    logic [DW-1:0]         reg_q [REGISTERS];
    logic [REGISTERS-1:0]  written_q;

    read_state_t           state_q;
    read_state_t           state_d;
    logic [IDX_W-1:0]      ar_index;
    logic                  ar_in_range;
    logic                  ar_hs;
    logic [DW-1:0]         rd_value;
    logic [DW-1:0]         rdata_q;
    response_t             rresp_q;
    logic                  unused_araddr_bits;

    logic_axi4_lite_register_bank_write #(
        .DATA_BYTES    (DATA_BYTES),
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .REGISTERS     (REGISTERS)
    ) u_write (
        .aclk     (aclk),
        .areset_n (areset_n),
        .awvalid  (bus.awvalid),
        .awready  (bus.awready),
        .awaddr   (bus.awaddr),
        .wvalid   (bus.wvalid),
        .wready   (bus.wready),
        .wdata    (bus.wdata),
        .wstrb    (bus.wstrb),
        .bvalid   (bus.bvalid),
        .bready   (bus.bready),
        .bresp    (bus.bresp),
        .commit   (commit),
        .index    (wr_index),
        .strobe   (wr_strobe),
        .data     (wr_data),
        .in_range (wr_in_range)
    );

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            for (int r = 0; r < REGISTERS; r++) begin
                reg_q[r] <= '0;
            end
            written_q <= '0;
        end else begin
            for (int r = 0; r < REGISTERS; r++) begin
                written_q[r] <= commit && wr_in_range && (wr_index == IDX_W'(r)) && (|wr_strobe);
                for (int k = 0; k < DATA_BYTES; k++) begin
                    if (commit && wr_in_range && (wr_index == IDX_W'(r)) && wr_strobe[k]) begin
                        reg_q[r][8*k +: 8] <= wr_data[8*k +: 8];
                    end
                end
            end
        end
    end

    for (genvar r = 0; r < REGISTERS; r++) begin : g_export
        assign registers[r*DW +: DW] = reg_q[r];
    end
    assign written = written_q;

    // Read channel
    assign unused_araddr_bits = ^bus.araddr;
    assign ar_index    = bus.araddr[ADDRESS_WIDTH-1:LSB];
    assign ar_in_range = ({1'b0, ar_index} < (IDX_W+1)'(REGISTERS));
    assign bus.arready = (state_q == READ_IDLE);
    assign ar_hs       = bus.arvalid && bus.arready;
    assign bus.rvalid  = (state_q == READ_RESP);
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

    // Out-of-range indices match no register and read as zero.
    always_comb begin
        rd_value = '0;
        for (int r = 0; r < REGISTERS; r++) begin
            if (ar_index == IDX_W'(r)) begin
                rd_value = reg_q[r];
            end
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= READ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            READ_IDLE: if (bus.arvalid) state_d = READ_RESP;
            READ_RESP: if (bus.rready)  state_d = READ_IDLE;
            default:   state_d = READ_IDLE;
        endcase
    end

    // Sampled from the pre-edge register value, so a same-edge write is not visible.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata_q <= ar_in_range ? rd_value : '0;
            rresp_q <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
        end
    end

endmodule

// File: tb/tb_logic_axi4_lite_register_bank.sv
// tb/tb_logic_axi4_lite_register_bank.sv - self-checking bench for logic_axi4_lite_register_bank
module tb_logic_axi4_lite_register_bank;

    logic         aclk;
    logic         areset_n;
    logic [127:0] registers;
    logic [3:0]   written;
    int           total;
    int           bad;

    logic_axi4_lite_register_bank_if #(.ADDRESS_WIDTH(8), .DATA_BYTES(4)) bus ();

    logic_axi4_lite_register_bank #(
        .DATA_BYTES    (4),
        .ADDRESS_WIDTH (8),
        .REGISTERS     (4)
    ) dut (
        .aclk      (aclk),
        .areset_n  (areset_n),
        .bus       (bus),
        .registers (registers),
        .written   (written)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [7:0]   addr;
        logic [31:0]  wdata;
        logic [3:0]   wstrb;
        logic [1:0]   bresp;
        logic [3:0]   written;
        logic [127:0] regs;
        logic [7:0]   raddr;
        logic [31:0]  rdata;
        logic [1:0]   rresp;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [3:0] pulse);
        int n;
        @(posedge aclk); #1;
        bus.awvalid = 1'b1; bus.awaddr = addr;
        bus.wvalid  = 1'b1; bus.wdata  = data; bus.wstrb = strb;
        n = 0;
        @(negedge aclk);
        while (!(bus.awready && bus.wready) && n < 20) begin
            @(negedge aclk);
            n++;
        end
        check("aw_w_accept", (n < 20), 1'b1);
        @(posedge aclk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge aclk);
        check("b_latency", bus.bvalid, 1'b1);
        resp  = bus.bresp;
        pulse = written;
        bus.bready = 1'b1;
        @(posedge aclk); #1;
        bus.bready = 1'b0;
        @(negedge aclk);
        check("written_one_cycle", written, 4'b0000);
        check("bvalid_clear", bus.bvalid, 1'b0);
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        @(posedge aclk); #1;
        bus.arvalid = 1'b1; bus.araddr = addr;
        n = 0;
        @(negedge aclk);
        while (!bus.arready && n < 20) begin
            @(negedge aclk);
            n++;
        end
        check("ar_accept", (n < 20), 1'b1);
        @(posedge aclk); #1;
        bus.arvalid = 1'b0;
        @(negedge aclk);
        check("r_latency", bus.rvalid, 1'b1);
        data = bus.rdata;
        resp = bus.rresp;
        bus.rready = 1'b1;
        @(posedge aclk); #1;
        bus.rready = 1'b0;
        @(negedge aclk);
        check("rvalid_clear", bus.rvalid, 1'b0);
    endtask

    initial begin
        logic [1:0]  resp;
        logic [3:0]  pulse;
        logic [31:0] rd;
        int          pulses;

        total = 0;
        bad   = 0;

        vecs[0] = '{8'h04, 32'hDEADBEEF, 4'hF, 2'b00, 4'b0010,
                    {32'h0, 32'h0, 32'hDEADBEEF, 32'h0},
                    8'h04, 32'hDEADBEEF, 2'b00};
        vecs[1] = '{8'h00, 32'h11223344, 4'h5, 2'b00, 4'b0001,
                    {32'h0, 32'h0, 32'hDEADBEEF, 32'h00220044},
                    8'h00, 32'h00220044, 2'b00};
        vecs[2] = '{8'h10, 32'hFFFFFFFF, 4'hF, 2'b10, 4'b0000,
                    {32'h0, 32'h0, 32'hDEADBEEF, 32'h00220044},
                    8'h10, 32'h0, 2'b10};
        vecs[3] = '{8'h0E, 32'hCAFEF00D, 4'hC, 2'b00, 4'b1000,
                    {32'hCAFE0000, 32'h0, 32'hDEADBEEF, 32'h00220044},
                    8'h0C, 32'hCAFE0000, 2'b00};
        vecs[4] = '{8'h0C, 32'h12345678, 4'h0, 2'b00, 4'b0000,
                    {32'hCAFE0000, 32'h0, 32'hDEADBEEF, 32'h00220044},
                    8'h0C, 32'hCAFE0000, 2'b00};
        vecs[5] = '{8'h1C, 32'h87654321, 4'hF, 2'b10, 4'b0000,
                    {32'hCAFE0000, 32'h0, 32'hDEADBEEF, 32'h00220044},
                    8'h1C, 32'h0, 2'b10};

        areset_n    = 1'b0;
        bus.awvalid = 1'b0; bus.awaddr = '0;
        bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb = '0;
        bus.bready  = 1'b0;
        bus.arvalid = 1'b0; bus.araddr = '0;
        bus.rready  = 1'b0;

        repeat (2) @(negedge aclk);
        check("rst_registers", registers, 128'h0);
        check("rst_written", written, 4'b0);
        check("rst_bvalid", bus.bvalid, 1'b0);
        check("rst_rvalid", bus.rvalid, 1'b0);
        check("rst_bresp", bus.bresp, 2'b00);
        check("rst_rresp", bus.rresp, 2'b00);
        check("rst_rdata", bus.rdata, 32'h0);
        areset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, resp, pulse);
            check($sformatf("v%0d_bresp", i), resp, vecs[i].bresp);
            check($sformatf("v%0d_written", i), pulse, vecs[i].written);
            check($sformatf("v%0d_registers", i), registers, vecs[i].regs);
            axi_read(vecs[i].raddr, rd, resp);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
            check($sformatf("v%0d_rresp", i), resp, vecs[i].rresp);
        end

        // W arrives three cycles ahead of AW
        @(posedge aclk); #1;
        bus.wvalid = 1'b1; bus.wdata = 32'h00001234; bus.wstrb = 4'h3;
        @(negedge aclk);
        check("early_w_wready", bus.wready, 1'b1);
        @(posedge aclk); #1;
        bus.wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("early_w_wready_low", bus.wready, 1'b0);
            check("early_w_awready", bus.awready, 1'b1);
            check("early_w_no_b", bus.bvalid, 1'b0);
        end
        @(posedge aclk); #1;
        bus.awvalid = 1'b1; bus.awaddr = 8'h04;
        @(negedge aclk);
        check("late_aw_awready", bus.awready, 1'b1);
        @(posedge aclk); #1;
        bus.awvalid = 1'b0;
        @(negedge aclk);
        check("late_aw_bvalid", bus.bvalid, 1'b1);
        check("late_aw_bresp", bus.bresp, 2'b00);
        check("late_aw_reg1", registers[63:32], 32'hDEAD1234);
        check("late_aw_written", written, 4'b0010);
        bus.bready = 1'b1;
        @(posedge aclk); #1;
        bus.bready = 1'b0;
        axi_read(8'h04, rd, resp);
        check("late_aw_read", rd, 32'hDEAD1234);
        check("late_aw_rresp", resp, 2'b00);

        // B and R back-pressure with concurrent write and read
        @(posedge aclk); #1;
        bus.awvalid = 1'b1; bus.awaddr = 8'h0C;
        bus.wvalid  = 1'b1; bus.wdata  = 32'h13579BDF; bus.wstrb = 4'hF;
        bus.arvalid = 1'b1; bus.araddr = 8'h00;
        @(negedge aclk);
        check("bp_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
        @(posedge aclk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check("bp_bvalid", bus.bvalid, 1'b1);
            check("bp_bresp", bus.bresp, 2'b00);
            check("bp_awready", bus.awready, 1'b0);
            check("bp_wready", bus.wready, 1'b0);
            if (i < 3) begin
                check("bp_rvalid", bus.rvalid, 1'b1);
                check("bp_rdata", bus.rdata, 32'h00220044);
            end
            if (i == 2) bus.rready = 1'b1;
            if (i == 3) begin
                bus.rready = 1'b0;
                check("bp_rvalid_clear", bus.rvalid, 1'b0);
            end
        end
        bus.bready = 1'b1;
        @(posedge aclk); #1;
        bus.bready = 1'b0;
        @(negedge aclk);
        check("bp_bvalid_clear", bus.bvalid, 1'b0);
        check("bp_reg3", registers[127:96], 32'h13579BDF);

        // Same-edge read and commit on register 2
        @(posedge aclk); #1;
        bus.awvalid = 1'b1; bus.awaddr = 8'h08;
        bus.wvalid  = 1'b1; bus.wdata  = 32'hA5A5A5A5; bus.wstrb = 4'hF;
        bus.arvalid = 1'b1; bus.araddr = 8'h08;
        @(negedge aclk);
        check("se_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
        @(posedge aclk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        @(negedge aclk);
        check("se_rvalid", bus.rvalid, 1'b1);
        check("se_old_value", bus.rdata, 32'h0);
        check("se_bvalid", bus.bvalid, 1'b1);
        bus.rready = 1'b1; bus.bready = 1'b1;
        @(posedge aclk); #1;
        bus.rready = 1'b0; bus.bready = 1'b0;
        axi_read(8'h08, rd, resp);
        check("se_new_value", rd, 32'hA5A5A5A5);

        // Reset with AW captured and W pending
        @(posedge aclk); #1;
        bus.awvalid = 1'b1; bus.awaddr = 8'h0C;
        @(negedge aclk);
        check("rr_awready", bus.awready, 1'b1);
        @(posedge aclk); #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b1; bus.wdata = 32'h55555555; bus.wstrb = 4'hF;
        @(negedge aclk);
        areset_n = 1'b0;
        #1;
        bus.wvalid = 1'b0;
        check("rr_registers", registers, 128'h0);
        check("rr_written", written, 4'b0);
        check("rr_bvalid", bus.bvalid, 1'b0);
        check("rr_rvalid", bus.rvalid, 1'b0);
        check("rr_bresp", bus.bresp, 2'b00);
        check("rr_rresp", bus.rresp, 2'b00);
        check("rr_rdata", bus.rdata, 32'h0);
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        areset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("rr_no_leftover", bus.bvalid, 1'b0);
        end
        @(posedge aclk); #1;
        bus.wvalid = 1'b1; bus.wdata = 32'h0BADC0DE; bus.wstrb = 4'hF;
        @(negedge aclk);
        check("rr_wready", bus.wready, 1'b1);
        @(posedge aclk); #1;
        bus.wvalid = 1'b0;
        @(negedge aclk);
        check("rr_no_stale_aw", bus.bvalid, 1'b0);
        @(posedge aclk); #1;
        bus.awvalid = 1'b1; bus.awaddr = 8'h0C;
        @(negedge aclk);
        check("rr_fresh_awready", bus.awready, 1'b1);
        @(posedge aclk); #1;
        bus.awvalid = 1'b0;
        @(negedge aclk);
        check("rr_fresh_bvalid", bus.bvalid, 1'b1);
        check("rr_fresh_bresp", bus.bresp, 2'b00);
        check("rr_fresh_regs", registers, {32'h0BADC0DE, 96'h0});
        bus.bready = 1'b1;
        @(posedge aclk); #1;
        bus.bready = 1'b0;
        pulses = 0;
        repeat (4) begin
            @(negedge aclk);
            if (bus.bvalid) pulses++;
        end
        check("rr_single_b", pulses, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
